// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: reads 16-bit words from an instruction RAM and
// delivers them to the consumer as a little-endian byte stream.
module instr_prefetch_queue #(
    parameter int unsigned AW         = 11,
    parameter int unsigned DEPTH      = 8,
    parameter logic [AW:0] RESET_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic [AW:0]              flush_addr,
    output logic [AW-1:0]            ram_adb,
    output logic                     ram_ceb,
    output logic                     ram_oce,
    input  logic [15:0]              ram_dout,
    output logic [7:0]               q_byte,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [AW:0]              fetch_addr
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam int unsigned CreditW = CW + 1;
    localparam int unsigned FW      = AW + 1;
    localparam logic [CreditW-1:0] DepthC = CreditW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, tail_q, tail_d;
    logic [AW-1:0] wptr_q;
    logic [FW-1:0] faddr_q;
    logic          skip_q;
    logic          inflight_q;
    logic          running_q;

    logic               issue, push, pop;
    logic [1:0]         push_cnt;
    logic [CreditW-1:0] credit;

    // Credit reserves room for the in-flight word and the one about to be issued.
    always_comb begin
        credit  = CreditW'(count_q) + CreditW'({inflight_q, 1'b0}) + CreditW'(2);
        issue   = running_q && !flush && (credit <= DepthC);
        push    = inflight_q && !flush;
        q_valid = (count_q != '0) && !flush;
        pop     = q_valid && q_ready;
        push_cnt = 2'd0;
        if (push) begin
            push_cnt = skip_q ? 2'd1 : 2'd2;
        end
        count_d = count_q + CW'(push_cnt) - CW'(pop);
        tail_d  = tail_q + PW'(push_cnt);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (skip_q) begin
                mem_q[tail_q] <= ram_dout[15:8];
            end else begin
                mem_q[tail_q]          <= ram_dout[7:0];
                mem_q[tail_q + PW'(1)] <= ram_dout[15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            wptr_q     <= RESET_ADDR[AW:1];
            faddr_q    <= RESET_ADDR;
            skip_q     <= 1'b0;
            inflight_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            running_q  <= 1'b1;
            inflight_q <= issue;
            if (flush) begin
                count_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                wptr_q  <= flush_addr[AW:1];
                faddr_q <= flush_addr;
                skip_q  <= flush_addr[0];
            end else begin
                count_q <= count_d;
                tail_q  <= tail_d;
                if (pop) begin
                    head_q  <= head_q + PW'(1);
                    faddr_q <= faddr_q + FW'(1);
                end
                if (issue) begin
                    wptr_q <= wptr_q + AW'(1);
                end
                // First edge out of reset behaves like a flush to RESET_ADDR.
                if (!running_q) begin
                    skip_q <= RESET_ADDR[0];
                end else if (push) begin
                    skip_q <= 1'b0;
                end
            end
        end
    end

    assign ram_adb    = wptr_q;
    assign ram_ceb    = issue;
    assign ram_oce    = 1'b1;
    assign q_byte     = mem_q[head_q];
    assign q_count    = count_q;
    assign fetch_addr = faddr_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a synchronous RAM model whose
// contents come from a fixed hash of the word address.
module tb_instr_prefetch_queue;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [11:0] flush_addr;
    logic [10:0] ram_adb;
    logic        ram_ceb;
    logic        ram_oce;
    logic [15:0] ram_dout;
    logic [7:0]  q_byte;
    logic        q_valid;
    logic        q_ready;
    logic [3:0]  q_count;
    logic [11:0] fetch_addr;

    int checks = 0;
    int errors = 0;

    instr_prefetch_queue dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .flush_addr (flush_addr),
        .ram_adb    (ram_adb),
        .ram_ceb    (ram_ceb),
        .ram_oce    (ram_oce),
        .ram_dout   (ram_dout),
        .q_byte     (q_byte),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_count    (q_count),
        .fetch_addr (fetch_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [10:0] a);
        logic [15:0] t;
        t = {5'd0, a} * 16'd40503;
        return t ^ 16'h5A3C;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [11:0] ba);
        logic [15:0] w;
        w = word(ba[11:1]);
        return ba[0] ? w[15:8] : w[7:0];
    endfunction

    always @(posedge clk) begin
        if (ram_ceb) ram_dout <= word(ram_adb);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n;
        n = 0;
        while (!q_valid && n < limit) begin
            step();
            n++;
        end
        chk(name, q_valid, 1);
    endtask

    // Pulse flush across exactly one rising edge, leaving the bench in the next cycle.
    task automatic do_flush(input logic [11:0] a);
        flush      = 1'b1;
        flush_addr = a;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [10:0] adb0;
        logic [10:0] adb1;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int issued;
        logic [11:0] a1, a2;

        vecs[0] = '{12'h00B, 11'h005, 11'h006, exp_byte(12'h00B), exp_byte(12'h00C), exp_byte(12'h00D)};
        vecs[1] = '{12'h000, 11'h000, 11'h001, exp_byte(12'h000), exp_byte(12'h001), exp_byte(12'h002)};
        vecs[2] = '{12'h3A5, 11'h1D2, 11'h1D3, exp_byte(12'h3A5), exp_byte(12'h3A6), exp_byte(12'h3A7)};
        vecs[3] = '{12'hFFE, 11'h7FF, 11'h000, exp_byte(12'hFFE), exp_byte(12'hFFF), exp_byte(12'h000)};
        vecs[4] = '{12'hFFF, 11'h7FF, 11'h000, exp_byte(12'hFFF), exp_byte(12'h000), exp_byte(12'h001)};
        vecs[5] = '{12'h400, 11'h200, 11'h201, exp_byte(12'h400), exp_byte(12'h401), exp_byte(12'h402)};

        resetn     = 1'b0;
        flush      = 1'b0;
        flush_addr = '0;
        q_ready    = 1'b0;

        // Reset state, then fill with no consumer.
        step();
        chk("rst_valid", q_valid, 0);
        chk("rst_ceb", ram_ceb, 0);
        chk("rst_count", q_count, 0);
        chk("rst_fetch_addr", fetch_addr, 0);
        chk("oce", ram_oce, 1);
        resetn = 1'b1;
        issued = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ram_ceb) begin
                chk("fill_adb", ram_adb, issued);
                issued++;
            end
        end
        chk("fill_reads", issued, 4);
        chk("fill_ceb_idle", ram_ceb, 0);
        chk("fill_count", q_count, 8);
        chk("fill_valid", q_valid, 1);
        chk("fill_byte", q_byte, exp_byte(12'h000));
        chk("fill_fetch_addr", fetch_addr, 0);

        // Streaming after reset with the consumer always ready.
        resetn = 1'b0;
        step();
        resetn  = 1'b1;
        q_ready = 1'b1;
        wait_valid(10, "stream_first_valid");
        for (int k = 0; k < 40; k++) begin
            chk("stream_valid", q_valid, 1);
            chk("stream_byte", q_byte, exp_byte(12'(k)));
            chk("stream_fetch_addr", fetch_addr, k);
            step();
        end

        // Flush targets, including odd start and address wrap.
        for (int i = 0; i < 6; i++) begin
            q_ready = 1'b0;
            do_flush(vecs[i].addr);
            chk("vec_ceb0", ram_ceb, 1);
            chk("vec_adb0", ram_adb, vecs[i].adb0);
            chk("vec_empty0", q_valid, 0);
            step();
            chk("vec_ceb1", ram_ceb, 1);
            chk("vec_adb1", ram_adb, vecs[i].adb1);
            chk("vec_empty1", q_valid, 0);
            step();
            a1 = vecs[i].addr + 12'd1;
            a2 = vecs[i].addr + 12'd2;
            chk("vec_valid", q_valid, 1);
            chk("vec_b0", q_byte, vecs[i].b0);
            chk("vec_addr0", fetch_addr, vecs[i].addr);
            q_ready = 1'b1;
            step();
            chk("vec_b1", q_byte, vecs[i].b1);
            chk("vec_addr1", fetch_addr, a1);
            step();
            chk("vec_b2", q_byte, vecs[i].b2);
            chk("vec_addr2", fetch_addr, a2);
        end

        // Flush while a read is in flight: the stale word must be dropped.
        q_ready = 1'b0;
        do_flush(12'h100);
        chk("stale_issue", ram_ceb, 1);
        step();
        flush      = 1'b1;
        flush_addr = 12'h201;
        #1 chk("stale_ceb_gated", ram_ceb, 0);
        chk("stale_valid_gated", q_valid, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("stale_adb", ram_adb, 11'h100);
        step();
        step();
        chk("stale_valid", q_valid, 1);
        chk("stale_count", q_count, 1);
        chk("stale_byte", q_byte, exp_byte(12'h201));
        chk("stale_addr", fetch_addr, 12'h201);
        q_ready = 1'b1;
        step();
        chk("stale_next", q_byte, exp_byte(12'h202));
        chk("stale_next_addr", fetch_addr, 12'h202);

        // Asynchronous reset mid-stream, then restart from RESET_ADDR.
        repeat (5) step();
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_valid", q_valid, 0);
        chk("async_ceb", ram_ceb, 0);
        chk("async_count", q_count, 0);
        chk("async_fetch_addr", fetch_addr, 0);
        @(negedge clk);
        resetn = 1'b1;
        wait_valid(10, "restart_valid");
        chk("restart_byte", q_byte, exp_byte(12'h000));
        chk("restart_addr", fetch_addr, 0);
        step();
        chk("restart_byte1", q_byte, exp_byte(12'h001));
        chk("restart_addr1", fetch_addr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
